// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: routes a valid/ready stream to one of N_CH registered outputs, or broadcasts it to all of them
module stream_demux_1xn #(
  parameter int DATA_W = 8,
  parameter int N_CH = 8,
  parameter int SEL_W = $clog2(N_CH),
  parameter int ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   bcast,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [ERR_W-1:0]       err_cnt
);
  logic [N_CH-1:0] free;
  logic [N_CH-1:0] load;
  logic legal;
  logic acc;
  assign free = ~out_valid | out_ready;
  assign legal = {1'b0, in_sel} < (SEL_W+1)'(N_CH);
  assign in_ready = bcast ? &free : legal ? free[in_sel] : 1'b1;
  assign acc = in_valid && in_ready;
  // select which slots capture the accepted word
  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++)
      load[k] = acc && (bcast || (legal && in_sel == SEL_W'(k)));
  end
  // per-channel holding registers: reload wins over drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (load[k]) begin
          out_valid[k] <= 1'b1;
          out_data[k*DATA_W +: DATA_W] <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end
  // saturating count of words discarded for an out-of-range select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (acc && !bcast && !legal && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end
endmodule

// File: tb/tb_stream_demux_1xn.sv
// tb_stream_demux_1xn: directed tests for the registered 1xN stream demultiplexer
module tb_stream_demux_1xn;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0, in_ready, bcast = 0;
  logic [7:0] in_data = 0;
  logic [2:0] in_sel = 0;
  logic [7:0] out_valid, out_ready = '1, err_cnt;
  logic [63:0] out_data;
  logic in_valid6 = 0, in_ready6, in_ready6s;
  logic [7:0] in_data6 = 0;
  logic [2:0] in_sel6 = 0;
  logic [5:0] out_valid6, out_valid6s, out_ready6 = '1;
  logic [47:0] out_data6, out_data6s;
  logic [7:0] err6;
  logic [1:0] err6s;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  stream_demux_1xn dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .bcast(bcast), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_cnt(err_cnt));
  stream_demux_1xn #(.N_CH(6)) dut6 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid6),
    .in_ready(in_ready6), .in_data(in_data6), .in_sel(in_sel6), .bcast(1'b0),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6), .err_cnt(err6));
  stream_demux_1xn #(.N_CH(6), .ERR_W(2)) dut6s (.clk(clk), .rst_n(rst_n), .in_valid(in_valid6),
    .in_ready(in_ready6s), .in_data(in_data6), .in_sel(in_sel6), .bcast(1'b0),
    .out_valid(out_valid6s), .out_ready(out_ready6), .out_data(out_data6s), .err_cnt(err6s));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 8'h00) $display("FAIL reset_valid got %h want 00", out_valid); else passed++;
    checks++; if (out_data !== 64'h0) $display("FAIL reset_data got %h want 0", out_data); else passed++;
    checks++; if (err_cnt !== 8'h00) $display("FAIL reset_err got %h want 00", err_cnt); else passed++;
    in_sel = 3;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else passed++;
    step();
    rst_n = 1;
  endtask

  task automatic test_unicast();
    out_ready = '1; in_valid = 1; in_data = 8'hA5; in_sel = 3;
    checks++; if (in_ready !== 1'b1) $display("FAIL uni_ready got %b want 1", in_ready); else passed++;
    step();
    in_valid = 0;
    checks++; if (out_valid !== 8'h08) $display("FAIL uni_valid got %h want 08", out_valid); else passed++;
    checks++; if (out_data !== 64'h0000_0000_A500_0000) $display("FAIL uni_data got %h want 00000000a5000000", out_data); else passed++;
    step();
    checks++; if (out_valid !== 8'h00) $display("FAIL uni_drain got %h want 00", out_valid); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 8'hFB; in_valid = 1; in_data = 8'h11; in_sel = 2;
    step();
    checks++; if (out_valid !== 8'h04 || out_data[23:16] !== 8'h11) $display("FAIL bp_first got %h/%h want 04/11", out_valid, out_data[23:16]); else passed++;
    in_data = 8'h22;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_stall got %b want 0", in_ready); else passed++;
      checks++; if (out_valid !== 8'h04 || out_data[23:16] !== 8'h11) $display("FAIL bp_hold got %h/%h want 04/11", out_valid, out_data[23:16]); else passed++;
      step();
    end
    out_ready = '1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_release got %b want 1", in_ready); else passed++;
    step();
    checks++; if (out_valid !== 8'h04 || out_data[23:16] !== 8'h22) $display("FAIL bp_second got %h/%h want 04/22", out_valid, out_data[23:16]); else passed++;
    in_data = 8'h33; in_sel = 5;
    step();
    in_valid = 0;
    checks++; if (out_valid !== 8'h20 || out_data[47:40] !== 8'h33) $display("FAIL bp_third got %h/%h want 20/33", out_valid, out_data[47:40]); else passed++;
    step();
    checks++; if (out_valid !== 8'h00) $display("FAIL bp_empty got %h want 00", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = '1; in_valid = 1; in_sel = 1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i);
      checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", i, in_ready); else passed++;
      step();
      checks++; if (out_valid !== 8'h02 || out_data[15:8] !== 8'(i)) $display("FAIL b2b_word%0d got %h/%h want 02/%h", i, out_valid, out_data[15:8], 8'(i)); else passed++;
    end
    in_valid = 0;
    step();
    checks++; if (out_valid !== 8'h00) $display("FAIL b2b_end got %h want 00", out_valid); else passed++;
  endtask

  task automatic test_broadcast();
    out_ready = 8'hBF; in_valid = 1; in_data = 8'h66; in_sel = 6;
    step();
    bcast = 1; in_data = 8'h5A; in_sel = 0;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL bc_gate got %b want 0", in_ready); else passed++;
    step();
    checks++; if (out_valid !== 8'h40 || out_data[55:48] !== 8'h66) $display("FAIL bc_nochange got %h/%h want 40/66", out_valid, out_data[55:48]); else passed++;
    out_ready = '1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL bc_open got %b want 1", in_ready); else passed++;
    step();
    in_valid = 0; bcast = 0;
    checks++; if (out_valid !== 8'hFF || out_data !== {8{8'h5A}}) $display("FAIL bc_all got %h/%h want ff/5a5a5a5a5a5a5a5a", out_valid, out_data); else passed++;
    step();
    checks++; if (out_valid !== 8'h00) $display("FAIL bc_drain got %h want 00", out_valid); else passed++;
  endtask

  task automatic test_illegal();
    out_ready6 = 6'h3E; in_valid6 = 1; in_data6 = 8'h77; in_sel6 = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      in_sel6 = i < 3 ? 3'd6 : 3'd7; in_data6 = 8'(8'hE0 + i);
      #1;
      checks++; if (in_ready6 !== 1'b1 || in_ready6s !== 1'b1) $display("FAIL ill_ready%0d got %b%b want 11", i, in_ready6, in_ready6s); else passed++;
      step();
      if (i == 4) begin
        checks++; if (err6 !== 8'd5 || err6s !== 2'd3) $display("FAIL ill_five got %0d/%0d want 5/3", err6, err6s); else passed++;
      end
    end
    in_valid6 = 0;
    checks++; if (err6 !== 8'd6) $display("FAIL ill_count got %0d want 6", err6); else passed++;
    checks++; if (err6s !== 2'd3) $display("FAIL ill_sat got %0d want 3", err6s); else passed++;
    checks++; if (out_valid6 !== 6'h01 || out_data6 !== 48'h77) $display("FAIL ill_slots got %h/%h want 01/77", out_valid6, out_data6); else passed++;
    checks++; if (out_valid6s !== 6'h01 || out_data6s !== 48'h77) $display("FAIL ill_slots_s got %h/%h want 01/77", out_valid6s, out_data6s); else passed++;
  endtask

  task automatic test_async_reset();
    out_ready = 8'h00; in_valid = 1; in_data = 8'h10; in_sel = 0;
    step();
    in_data = 8'h14; in_sel = 4;
    step();
    in_valid = 0;
    checks++; if (out_valid !== 8'h11) $display("FAIL ar_fill got %h want 11", out_valid); else passed++;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 8'h00) $display("FAIL ar_valid got %h want 00", out_valid); else passed++;
    checks++; if (err6 !== 8'd0 || out_valid6 !== 6'h00) $display("FAIL ar_err got %0d/%h want 0/00", err6, out_valid6); else passed++;
    #1 rst_n = 1;
    out_ready = '1; in_valid = 1; in_data = 8'hC3; in_sel = 4;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL ar_ready got %b want 1", in_ready); else passed++;
    step();
    in_valid = 0;
    checks++; if (out_valid !== 8'h10 || out_data[39:32] !== 8'hC3) $display("FAIL ar_resume got %h/%h want 10/c3", out_valid, out_data[39:32]); else passed++;
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_back_to_back();
    test_broadcast();
    test_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/stream_demux_1xn.md
Name: stream_demux_1xn

Overview:
- Parametrised, registered successor to the fixed 1x8 combinational demultiplexer.
- Routes a valid/ready input stream to one of N_CH output streams by `in_sel`, or to all of them in broadcast mode.
- Each output has a one-entry holding register, so one slow consumer only back-pressures traffic addressed to that channel.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
- DATA_W, 8, width of the data word.
- N_CH, 8, number of output channels; legal range 2..64.
- SEL_W, $clog2(N_CH), width of the channel-select field. It is derived; do not override it.
- ERR_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  DATA_W  input word.
- in_sel  in  SEL_W  destination channel index.
- bcast  in  1  1 = copy the word to every channel. Sampled with in_valid.
- out_valid  out  N_CH  per-channel valid; bit k belongs to channel k.
- out_ready  in  N_CH  per-channel consumer ready.
- out_data  out  N_CH*DATA_W  flattened; channel k occupies bits [k*DATA_W +: DATA_W].
- err_cnt  out  ERR_W  count of words dropped for an illegal select.

Behaviour:
- Reset (rst_n low, asynchronous): all out_valid = 0, all out_data = 0, err_cnt = 0.
- in_ready is combinational and valid during reset release.
- Channel k is free when `!out_valid[k] || out_ready[k]`, so a drain and a refill can happen in the same cycle.
- Accept = in_valid && in_ready. Latency is 1 cycle: a word accepted at edge t is visible on out_valid/out_data after edge t.
- Unicast (bcast = 0, in_sel < N_CH):
  - in_ready = free[in_sel].
  - On accept, slot in_sel loads in_data and sets valid.
- Broadcast (bcast = 1, in_sel ignored):
  - in_ready = AND of free[k] over all k.
  - On accept, all slots load in_data and set valid in the same cycle.
  - No partial delivery is allowed.
- Illegal select (bcast = 0, in_sel >= N_CH; possible only when N_CH is not a power of two):
  - in_ready = 1 and the word is consumed and discarded.
  - No slot changes.
  - err_cnt increments by 1 and saturates at 2^ERR_W-1; it never wraps.
- Output drain: when out_valid[k] && out_ready[k] and channel k is not reloaded that cycle, out_valid[k] clears.
  - out_data[k] keeps its last value; it is don't-care while invalid.
- Hold rule: while out_valid[k] = 1 && out_ready[k] = 0, out_data[k] is stable.
- Channels are independent. Draining channel j never affects channel k.
- Input protocol requirement: in_data, in_sel and bcast must be held stable while in_valid = 1 && in_ready = 0.
  - in_ready has no combinational dependence on in_valid.
- Reset mid-operation: held words are lost and err_cnt clears. After release, all channels are free.
- Simultaneous events: a broadcast accept coinciding with drains on some channels reloads every channel. The drained channels therefore stay valid with the new word.

Test Plan:
- Reset + unicast: assert rst_n = 0, release. Send in_data = 0xA5, in_sel = 3, out_ready = all 1.
  - out_valid = 8'b0000_1000 for exactly one cycle, out_data[3] = 0xA5, all other bits 0.
- Back-pressure isolation:
  - out_ready[2] = 0. Send 0x11 to ch2, then 0x22 to ch2, then 0x33 to ch5.
  - Second word stalls with in_ready = 0 until out_ready[2] = 1.
  - ch2 holds 0x11 stable while stalled; 0x33 reaches ch5 only after the stall clears, with no reordering.
- Same-cycle drain/refill:
  - out_ready[1] = 1 continuously. Stream 0x01..0x08 to ch1 back-to-back.
  - in_ready stays 1, out_valid[1] stays 1 for 8 consecutive cycles, data matches in order.
- Broadcast gating:
  - out_ready[6] = 0 and ch6 full. bcast = 1, in_data = 0x5A.
  - in_ready = 0 and no channel changes. Raise out_ready[6]: all 8 channels show 0x5A on the next cycle.
- Illegal select:
  - Build with N_CH = 6. Send in_sel = 6 and 7, 3 words each.
  - in_ready = 1, out_valid unchanged, err_cnt = 6.
  - With ERR_W = 2, 5 illegal words give err_cnt = 3 (saturated).
- Asynchronous reset mid-stream:
  - Fill ch0 and ch4 with out_ready = 0, then pulse rst_n low between clock edges.
  - out_valid = 0 and err_cnt = 0 immediately, without waiting for a clock edge. Traffic resumes normally after release.
